// File: rtl/red_laser_driver.sv
// -----------------------------------------------------------------------------
// red_laser_driver
//   Drives the red aiming-laser diode with a soft-start / soft-stop PWM.
//   The request level comes from the upstream request stage (already
//   qualified). The main-laser interlock forces the diode dark immediately.
//   The block also enforces a maximum continuous on-time and a lockout
//   dwell after any fault.
//
//   Ports
//     clk_in       in   system clock (32 MHz)
//     rstn_i       in   asynchronous active-low reset
//     req_in       in   red-laser request level, synchronous to clk_in
//     intlk_in     in   1 = main laser armed/fault, red laser must be dark
//     pwm_out      out  registered diode drive
//     las_on       out  1 while in ON (full duty reached)
//     timeout_flag out  set by a max-on timeout, cleared on LOCKOUT exit
//     intlk_flag   out  set by an interlock hit, cleared on LOCKOUT exit
//     state_o      out  FSM state: IDLE=0 RAMP_UP=1 ON=2 RAMP_DOWN=3 LOCKOUT=4
// -----------------------------------------------------------------------------
module red_laser_driver #(
   parameter logic [15:0] PWM_PERIOD    = 16'd3200,
   parameter logic [15:0] DUTY_MAX      = 16'd1600,
   parameter logic [15:0] DUTY_STEP     = 16'd16,
   parameter logic [15:0] RAMP_STEP_CYC = 16'd3200,
   parameter logic [31:0] MAX_ON_CYC    = 32'd1920000000,
   parameter logic [25:0] LOCKOUT_CYC   = 26'd9600000
) (
   input  logic       clk_in,
   input  logic       rstn_i,
   input  logic       req_in,
   input  logic       intlk_in,
   output logic       pwm_out,
   output logic       las_on,
   output logic       timeout_flag,
   output logic       intlk_flag,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RAMP_UP   = 3'd1,
      S_ON        = 3'd2,
      S_RAMP_DOWN = 3'd3,
      S_LOCKOUT   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] duty_q, duty_d;
   logic [15:0] step_cnt_q, step_cnt_d;
   logic [31:0] on_cnt_q, on_cnt_d;
   logic [25:0] lock_cnt_q, lock_cnt_d;
   logic        timeout_q, timeout_d;
   logic        intlk_flag_q, intlk_flag_d;
   logic        las_on_q;

   logic [15:0] pwm_cnt_q;
   logic [15:0] duty_shadow_q;
   logic        pwm_q;

   logic        step_done;
   logic [16:0] duty_sum;
   logic [15:0] duty_up;
   logic [15:0] duty_dn;

   // Ramp arithmetic: 17-bit sum so the saturation compare cannot wrap.
   assign step_done = (step_cnt_q == RAMP_STEP_CYC - 16'd1);
   assign duty_sum  = {1'b0, duty_q} + {1'b0, DUTY_STEP};
   assign duty_up   = (duty_sum >= {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_sum[15:0];
   assign duty_dn   = (duty_q > DUTY_STEP) ? (duty_q - DUTY_STEP) : 16'd0;

   // ---------------- state register ----------------
   always_ff @(posedge clk_in or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= S_IDLE;
         duty_q       <= 16'd0;
         step_cnt_q   <= 16'd0;
         on_cnt_q     <= 32'd0;
         lock_cnt_q   <= 26'd0;
         timeout_q    <= 1'b0;
         intlk_flag_q <= 1'b0;
         las_on_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         duty_q       <= duty_d;
         step_cnt_q   <= step_cnt_d;
         on_cnt_q     <= on_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
         timeout_q    <= timeout_d;
         intlk_flag_q <= intlk_flag_d;
         las_on_q     <= (state_d == S_ON);
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d      = state_q;
      duty_d       = duty_q;
      step_cnt_d   = step_cnt_q;
      on_cnt_d     = on_cnt_q;
      lock_cnt_d   = lock_cnt_q;
      timeout_d    = timeout_q;
      intlk_flag_d = intlk_flag_q;

      if (intlk_in) begin
         // Interlock outranks everything, in every state.
         duty_d       = 16'd0;
         intlk_flag_d = 1'b1;
         lock_cnt_d   = 26'd0;
         state_d      = S_LOCKOUT;
      end else begin
         case (state_q)
            S_IDLE: begin
               duty_d = 16'd0;
               if (req_in) begin
                  state_d    = S_RAMP_UP;
                  step_cnt_d = 16'd0;
               end
            end
            S_RAMP_UP: begin
               if (!req_in) begin
                  // Ramp down from wherever the ramp had reached.
                  state_d    = S_RAMP_DOWN;
                  step_cnt_d = 16'd0;
               end else if (duty_q == DUTY_MAX) begin
                  state_d  = S_ON;
                  on_cnt_d = 32'd0;
               end else if (step_done) begin
                  step_cnt_d = 16'd0;
                  duty_d     = duty_up;
               end else begin
                  step_cnt_d = step_cnt_q + 16'd1;
               end
            end
            S_ON: begin
               on_cnt_d = on_cnt_q + 32'd1;
               if (on_cnt_q == MAX_ON_CYC - 32'd1) begin
                  // Timeout wins over a request drop in the same cycle.
                  timeout_d  = 1'b1;
                  state_d    = S_RAMP_DOWN;
                  step_cnt_d = 16'd0;
               end else if (!req_in) begin
                  state_d    = S_RAMP_DOWN;
                  step_cnt_d = 16'd0;
               end
            end
            S_RAMP_DOWN: begin
               if (duty_q == 16'd0) begin
                  lock_cnt_d = 26'd0;
                  state_d    = timeout_q ? S_LOCKOUT : S_IDLE;
               end else if (step_done) begin
                  step_cnt_d = 16'd0;
                  duty_d     = duty_dn;
               end else begin
                  step_cnt_d = step_cnt_q + 16'd1;
               end
            end
            S_LOCKOUT: begin
               duty_d = 16'd0;
               if (lock_cnt_q < LOCKOUT_CYC) begin
                  lock_cnt_d = lock_cnt_q + 26'd1;
               end
               // Requiring req_in low means a request held across the
               // lockout can never restart the laser.
               if ((lock_cnt_q >= LOCKOUT_CYC) && !req_in) begin
                  state_d      = S_IDLE;
                  timeout_d    = 1'b0;
                  intlk_flag_d = 1'b0;
               end
            end
            default: begin
               // Illegal codes recover through the safe dark state.
               duty_d     = 16'd0;
               lock_cnt_d = 26'd0;
               state_d    = S_LOCKOUT;
            end
         endcase
      end
   end

   // ---------------- output logic ----------------
   always_comb begin
      pwm_out      = pwm_q;
      las_on       = las_on_q;
      timeout_flag = timeout_q;
      intlk_flag   = intlk_flag_q;
      state_o      = state_q;
   end

   // ---------------- PWM generator ----------------
   // Duty is latched into the shadow at the end of each period so a period
   // never sees a partial update; the interlock bypasses this and goes dark
   // on the very next edge.
   always_ff @(posedge clk_in or negedge rstn_i) begin
      if (!rstn_i) begin
         pwm_cnt_q     <= 16'd0;
         duty_shadow_q <= 16'd0;
         pwm_q         <= 1'b0;
      end else begin
         if (pwm_cnt_q >= PWM_PERIOD - 16'd1) begin
            pwm_cnt_q <= 16'd0;
         end else begin
            pwm_cnt_q <= pwm_cnt_q + 16'd1;
         end

         if (intlk_in) begin
            duty_shadow_q <= 16'd0;
            pwm_q         <= 1'b0;
         end else begin
            if (pwm_cnt_q == PWM_PERIOD - 16'd1) begin
               duty_shadow_q <= duty_q;
            end
            pwm_q <= (pwm_cnt_q < duty_shadow_q);
         end
      end
   end

endmodule
